// File: rtl/rsc_pkg.sv
// rsc_pkg: shared FSM states, tail length, tap masks and default width for the RSC frame controller
package rsc_pkg;
  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
  localparam int TAIL_STEPS = 3;
  localparam logic [2:0] FB_TAPS = 3'b011;
  localparam logic [2:0] PAR_TAPS = 3'b101;
  localparam int LEN_W_DEF = 13;
endpackage

// File: rtl/rsc_state_reg.sv
// rsc_state_reg: 3-bit RSC encoder state {s1,s2,s3} (clk/rst/clr/en/u in; fb/par/s out), fb=s2^s3, par=u^fb^s1^s3
module rsc_state_reg
  import rsc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       u,
  output logic       fb,
  output logic       par,
  output logic [2:0] s
);
  logic a;
  assign fb = ^(s & FB_TAPS);
  assign a = u ^ fb;
  assign par = a ^ (^(s & PAR_TAPS));
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else if (clr) s <= '0;
    else if (en) s <= {a, s[2:1]};
endmodule

// File: rtl/rsc_frame_ctrl.sv
// rsc_frame_ctrl: RSC frame sequencer (start/frame_len, in_valid/in_ready/in_bit in; out_valid/out_ready/out_sys/out_par/out_tail/out_last, busy, done)
module rsc_frame_ctrl
  import rsc_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_sys,
  output logic             out_par,
  output logic             out_tail,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic [1:0] tail_cnt;
  logic slot_free, data_step, tail_step, step, accept, start_ok, tail_last, u, fb, par;
  logic [2:0] s;
  assign slot_free = !out_valid || out_ready;
  assign in_ready = state == DATA && slot_free;
  assign data_step = in_valid && in_ready;
  assign tail_step = state == TAIL && slot_free;
  assign step = data_step || tail_step;
  assign accept = out_valid && out_ready;
  assign start_ok = state == IDLE && start;
  assign tail_last = tail_cnt == 2'(TAIL_STEPS - 1);
  assign u = tail_step ? fb : in_bit;
  assign busy = state != IDLE;
  rsc_state_reg u_sr (
    .clk(clk),
    .rst(rst),
    .clr(start_ok),
    .en (step),
    .u  (u),
    .fb (fb),
    .par(par),
    .s  (s)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (frame_len == '0 ? TAIL : DATA) : IDLE;
      DATA:    state_nx = (data_step && cnt == LEN_W'(1)) ? TAIL : DATA;
      TAIL:    state_nx = (tail_step && tail_last) ? DRAIN : TAIL;
      default: state_nx = accept ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tail_cnt <= '0;
      done <= 1'b0;
      out_valid <= 1'b0;
      {out_sys, out_par, out_tail, out_last} <= '0;
    end else begin
      state <= state_nx;
      done <= state == DRAIN && accept;
      cnt <= start_ok ? frame_len : data_step ? cnt - LEN_W'(1) : cnt;
      tail_cnt <= start_ok ? 2'd0 : tail_step ? tail_cnt + 2'd1 : tail_cnt;
      if (step) begin
        out_valid <= 1'b1;
        {out_sys, out_par, out_tail, out_last} <= {u, par, tail_step, tail_step && tail_last};
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rsc_frame_ctrl.sv
// tb_rsc_frame_ctrl: table-driven and sequence checks of rsc_frame_ctrl
module tb_rsc_frame_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
  logic [12:0] frame_len = '0;
  logic in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, done;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rsc_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .in_valid(in_valid),
    .in_bit(in_bit), .in_ready(in_ready), .out_valid(out_valid), .out_sys(out_sys),
    .out_par(out_par), .out_tail(out_tail), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // e = {in_ready, out_valid, sys, par, tail, last, busy, done}
  typedef struct {
    logic st;
    logic [12:0] len;
    logic iv, ib, ordy;
    logic [7:0] e;
  } vec_t;
  vec_t vt[25];
  logic e_sys[64], e_par[64], e_tail[64], e_last[64];
  int e_n;
  function automatic void model(input int len, input logic [31:0] bits);
    logic s1, s2, s3, fb, a, uu;
    s1 = 0; s2 = 0; s3 = 0;
    e_n = len + 3;
    for (int k = 0; k < e_n; k++) begin
      fb = s2 ^ s3;
      uu = (k < len) ? bits[k] : fb;
      a = uu ^ fb;
      e_sys[k] = uu;
      e_par[k] = a ^ s1 ^ s3;
      e_tail[k] = k >= len;
      e_last[k] = k == e_n - 1;
      s3 = s2; s2 = s1; s1 = a;
    end
  endfunction
  task automatic run_frame(input string nm, input int len, input logic [31:0] bits, input bit stall,
                           input bit started, input bit chain, input int chain_len);
    int idx, got;
    bit done_seen, held;
    logic [3:0] hd;
    model(len, bits);
    if (!started) begin
      start = 1; frame_len = 13'(len);
      @(posedge clk); #1;
      start = 0;
    end
    idx = 0; got = 0; done_seen = 0; held = 0; hd = '0;
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      if (done) begin
        done_seen = 1;
        chk({nm, "_pairs"}, got, e_n);
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_state_zero"}, dut.u_sr.s, 0);
        if (chain) begin start = 1; frame_len = 13'(chain_len); end
      end
      out_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      in_valid = idx < len;
      in_bit = (idx < len) ? bits[idx] : 1'b0;
      #1;
      if (held) chk({nm, "_hold"}, {out_valid, out_sys, out_par, out_tail, out_last}, {1'b1, hd});
      held = out_valid && !out_ready;
      hd = {out_sys, out_par, out_tail, out_last};
      if (held) chk({nm, "_in_ready_stalled"}, in_ready, 0);
      if (out_valid && out_ready) begin
        if (got < e_n)
          chk({nm, "_pair"}, {out_sys, out_par, out_tail, out_last},
              {e_sys[got], e_par[got], e_tail[got], e_last[got]});
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      start = 0;
    end
    if (!done_seen) chk({nm, "_timeout"}, 0, 1);
    in_valid = 0; out_ready = 1;
  endtask
  initial begin
    vt[0]  = '{1, 4, 0, 0, 1, 8'b00000000};
    vt[1]  = '{0, 0, 1, 1, 1, 8'b10000010};
    vt[2]  = '{0, 0, 1, 0, 1, 8'b11110010};
    vt[3]  = '{0, 0, 1, 0, 1, 8'b11010010};
    vt[4]  = '{0, 0, 1, 0, 1, 8'b11010010};
    vt[5]  = '{0, 0, 0, 0, 1, 8'b01010010};
    vt[6]  = '{0, 0, 0, 0, 1, 8'b01111010};
    vt[7]  = '{0, 0, 0, 0, 1, 8'b01011010};
    vt[8]  = '{0, 0, 0, 0, 1, 8'b01111110};
    vt[9]  = '{0, 0, 0, 0, 1, 8'b00000001};
    vt[10] = '{0, 0, 0, 0, 1, 8'b00000000};
    vt[11] = '{1, 0, 0, 0, 1, 8'b00000000};
    vt[12] = '{0, 0, 1, 1, 1, 8'b00000010};
    vt[13] = '{0, 0, 0, 0, 1, 8'b01001010};
    vt[14] = '{0, 0, 0, 0, 1, 8'b01001010};
    vt[15] = '{0, 0, 0, 0, 1, 8'b01001110};
    vt[16] = '{0, 0, 0, 0, 1, 8'b00000001};
    vt[17] = '{1, 2, 0, 0, 1, 8'b00000000};
    vt[18] = '{1, 7, 1, 1, 1, 8'b10000010};
    vt[19] = '{1, 0, 1, 1, 1, 8'b11110010};
    vt[20] = '{0, 0, 0, 0, 1, 8'b01100010};
    vt[21] = '{0, 0, 0, 0, 1, 8'b01111010};
    vt[22] = '{0, 0, 0, 0, 1, 8'b01011010};
    vt[23] = '{0, 0, 0, 0, 1, 8'b01111110};
    vt[24] = '{0, 0, 0, 0, 1, 8'b00000001};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, done}, 0);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      start = vt[i].st; frame_len = vt[i].len; in_valid = vt[i].iv; in_bit = vt[i].ib;
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_ctrl", i), {in_ready, out_valid, busy, done},
          {vt[i].e[7], vt[i].e[6], vt[i].e[1], vt[i].e[0]});
      if (vt[i].e[6])
        chk($sformatf("vec%0d_pair", i), {out_sys, out_par, out_tail, out_last}, vt[i].e[5:2]);
      @(posedge clk); #1;
    end
    start = 0; in_valid = 0;
    chk("tbl_state_zero", dut.u_sr.s, 0);
    run_frame("stall", 4, 32'h1, 1, 0, 0, 0);
    run_frame("b2b_a", 3, 32'h5, 0, 0, 1, 4);
    run_frame("b2b_b", 4, 32'h1, 0, 1, 0, 0);
    run_frame("long", 11, 32'h5b3, 1, 0, 0, 0);
    start = 1; frame_len = 4;
    @(posedge clk); #1;
    start = 0; in_valid = 1; in_bit = 1;
    @(posedge clk); #1;
    in_bit = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_reset_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("mid_reset_outputs", {in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy, done}, 0);
    chk("mid_reset_state", dut.u_sr.s, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_frame("after_rst", 4, 32'h1, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
